// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock display scan path.
package clock_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  function automatic logic [3:0] digit_nibble(input logic [15:0] data,
                                              input logic [SEL_W-1:0] sel);
    return data[{sel, 2'b00} +: 4];
  endfunction

  // True when the selected digit and every more significant digit are zero.
  function automatic logic lz_blank(input logic [15:0] data,
                                    input logic [SEL_W-1:0] sel);
    return (sel != '0) && ((data >> {sel, 2'b00}) == '0);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Free-running phase counter: wraps to zero on the terminal count or on clear.
module scan_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == terminal);

  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed display scanner with blanking gaps and frame-aligned data updates.
// Optional leading-zero suppression: define DIGIT_SCAN_LZ_BLANK_EN.
module digit_scan_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [15:0]      digits_in,
  output logic [SEL_W-1:0] scan_sel,
  output logic             scan_active,
  output logic [3:0]       seg_bcd,
  output logic             frame_pulse
);

  localparam int unsigned MAX_CNT = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_PRE   = CNT_W'((SCAN_DIV >= 2) ? SCAN_DIV - 2 : 0);

  scan_state_t      state;
  logic [15:0]      shadow;
  logic [15:0]      pending;
  logic             pend_vld;
  logic [15:0]      shadow_nxt;
  logic [15:0]      pending_nxt;
  logic             pend_vld_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] terminal;
  logic             done;
  logic             timer_clear;
  logic             pulse_nxt;
  logic             show_en;
  logic [SEL_W-1:0] sel_inc;

  assign sel_inc     = scan_sel + SEL_W'(1);
  assign terminal    = (state == SHOW) ? SHOW_LAST : BLANK_LAST;
  assign timer_clear = (state == IDLE) || !enable;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .terminal (terminal),
    .count    (cnt),
    .done     (done)
  );

`ifdef DIGIT_SCAN_LZ_BLANK_EN
  assign show_en = !lz_blank(shadow, scan_sel);
`else
  assign show_en = 1'b1;
`endif

  // frame_pulse is registered, so it is high exactly during the boundary cycle
  // and doubles as the boundary qualifier for the buffer swap.
  always_comb begin
    shadow_nxt   = shadow;
    pending_nxt  = pending;
    pend_vld_nxt = pend_vld;
    if (state == IDLE) begin
      if (load) begin
        shadow_nxt   = digits_in;
        pend_vld_nxt = 1'b0;  // a direct load supersedes any stale staged value
      end
    end else if (frame_pulse) begin
      if (load) begin
        shadow_nxt   = digits_in;
        pend_vld_nxt = 1'b0;
      end else if (pend_vld) begin
        shadow_nxt   = pending;
        pend_vld_nxt = 1'b0;
      end
    end else if (load) begin
      pending_nxt  = digits_in;
      pend_vld_nxt = 1'b1;
    end
  end

  // Raise the pulse on the edge that enters the final SHOW cycle of digit 3.
  always_comb begin
    pulse_nxt = 1'b0;
    if (enable && (scan_sel == SEL_W'(NUM_DIGITS - 1))) begin
      if (state == BLANK && done && SCAN_DIV == 1) begin
        pulse_nxt = 1'b1;
      end else if (state == SHOW && !done && cnt == SHOW_PRE) begin
        pulse_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      pending     <= '0;
      pend_vld    <= 1'b0;
      scan_sel    <= '0;
      scan_active <= 1'b0;
      seg_bcd     <= '0;
      frame_pulse <= 1'b0;
    end else begin
      shadow      <= shadow_nxt;
      pending     <= pending_nxt;
      pend_vld    <= pend_vld_nxt;
      frame_pulse <= pulse_nxt;
      if (!enable) begin
        state       <= IDLE;
        scan_active <= 1'b0;
        scan_sel    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= BLANK;
            scan_sel    <= '0;
            scan_active <= 1'b0;
            seg_bcd     <= digit_nibble(shadow_nxt, '0);
          end
          BLANK: begin
            if (done) begin
              state       <= SHOW;
              scan_active <= show_en;
            end
          end
          SHOW: begin
            if (done) begin
              state       <= BLANK;
              scan_active <= 1'b0;
              scan_sel    <= sel_inc;
              seg_bcd     <= digit_nibble(shadow_nxt, sel_inc);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl with SCAN_DIV=4, BLANK_CYCLES=2.
module tb_digit_scan_ctrl;

  localparam int unsigned SD = 4;
  localparam int unsigned BC = 2;
  localparam int unsigned DIGIT_PERIOD = SD + BC;
  localparam int unsigned FRAME_PERIOD = 4 * (SD + BC);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [1:0]  scan_sel;
  logic        scan_active;
  logic [3:0]  seg_bcd;
  logic        frame_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] bcd;
  } exp_t;

  exp_t sbq[$];

  digit_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .digits_in   (digits_in),
    .scan_sel    (scan_sel),
    .scan_active (scan_active),
    .seg_bcd     (seg_bcd),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected shown digits of one frame (first n digits), honouring suppression when enabled.
  task automatic push_frame(input logic [15:0] v, input int unsigned n);
    exp_t e;
    logic [15:0] hi;
    for (int unsigned i = 0; i < n; i++) begin
      hi = v >> (4 * i);
`ifdef DIGIT_SCAN_LZ_BLANK_EN
      if (i != 0 && hi == 16'h0) continue;
`endif
      e.sel = 2'(i);
      e.bcd = hi[3:0];
      sbq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string name);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_pulse) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: frame_pulse not seen within 200 cycles", name);
  endtask

  task automatic wait_digit(input logic [1:0] s, input string name);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (scan_active && scan_sel == s) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: digit %0d not shown within 200 cycles", name, s);
  endtask

  // Monitor: pops an expectation at each rising scan_active and checks periodicity.
  logic        prev_active = 1'b0;
  int unsigned since_rise = 0;
  int unsigned since_pulse = 0;
  bit          have_rise = 1'b0;
  bit          have_pulse = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    since_rise++;
    since_pulse++;
    if (scan_active && !prev_active) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL show_unexpected: sel=%0d bcd=%0h shown, nothing expected", scan_sel, seg_bcd);
      end else begin
        e = sbq.pop_front();
        check("show_sel", 32'(scan_sel), 32'(e.sel));
        check("show_bcd", 32'(seg_bcd), 32'(e.bcd));
      end
`ifndef DIGIT_SCAN_LZ_BLANK_EN
      if (have_rise) check("digit_period", since_rise, DIGIT_PERIOD);
`endif
      since_rise = 0;
      have_rise  = 1'b1;
    end
    if (frame_pulse) begin
      check("pulse_sel", 32'(scan_sel), 32'd3);
`ifndef DIGIT_SCAN_LZ_BLANK_EN
      check("pulse_active", 32'(scan_active), 32'd1);
`endif
      if (have_pulse) check("frame_period", since_pulse, FRAME_PERIOD);
      since_pulse = 0;
      have_pulse  = 1'b1;
    end
    if (rst || !enable) begin
      have_rise  = 1'b0;
      have_pulse = 1'b0;
    end
    prev_active = scan_active;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    check("rst_sel", 32'(scan_sel), 32'd0);
    check("rst_active", 32'(scan_active), 32'd0);
    check("rst_bcd", 32'(seg_bcd), 32'd0);
    check("rst_pulse", 32'(frame_pulse), 32'd0);
    rst = 1'b0;

    // Idle load then scan.
    load = 1'b1; digits_in = 16'h1234; tick(); load = 1'b0;
    push_frame(16'h1234, 4);
    enable = 1'b1;

    // Mid-frame load must not tear the current frame.
    wait_digit(2'd1, "wait_f1_d1");
    load = 1'b1; digits_in = 16'h5678; tick(); load = 1'b0;
    push_frame(16'h5678, 4);
    wait_pulse("wait_f1");

    // Stage 0001, then collide 9999 with the frame boundary.
    repeat (3) tick();
    load = 1'b1; digits_in = 16'h0001; tick(); load = 1'b0;
    wait_pulse("wait_f2");
    load = 1'b1; digits_in = 16'h9999; tick(); load = 1'b0;
    push_frame(16'h9999, 4);
    push_frame(16'h9999, 4);
    wait_pulse("wait_f3");
    wait_pulse("wait_f4");

    // Disable during SHOW of digit 2.
    push_frame(16'h9999, 3);
    wait_digit(2'd2, "wait_f5_d2");
    enable = 1'b0;
    tick();
    check("dis_active", 32'(scan_active), 32'd0);
    check("dis_sel", 32'(scan_sel), 32'd0);
    tick();
    tick();

    // Re-enable: two blank cycles then digit 0.
    push_frame(16'h9999, 2);
    enable = 1'b1;
    tick();
    check("re_blank0_active", 32'(scan_active), 32'd0);
    check("re_blank0_sel", 32'(scan_sel), 32'd0);
    tick();
    check("re_blank1_active", 32'(scan_active), 32'd0);
    tick();
    check("re_show_active", 32'(scan_active), 32'd1);
    check("re_show_sel", 32'(scan_sel), 32'd0);

    // Reset mid-frame.
    wait_digit(2'd1, "wait_rst_point");
    rst = 1'b1;
    tick();
    check("mid_rst_sel", 32'(scan_sel), 32'd0);
    check("mid_rst_active", 32'(scan_active), 32'd0);
    check("mid_rst_bcd", 32'(seg_bcd), 32'd0);
    check("mid_rst_pulse", 32'(frame_pulse), 32'd0);
    rst = 1'b0;
    push_frame(16'h0000, 4);
    tick();
    check("post_rst_pulse", 32'(frame_pulse), 32'd0);
    wait_pulse("wait_post_rst");
    enable = 1'b0;
    tick();
    tick();

    // Leading-zero patterns (suppressed only when the feature is built in).
    load = 1'b1; digits_in = 16'h0030; tick(); load = 1'b0;
    push_frame(16'h0030, 4);
    enable = 1'b1;
    wait_pulse("wait_lz_0030");
    enable = 1'b0;
    tick();
    tick();
    load = 1'b1; digits_in = 16'h0000; tick(); load = 1'b0;
    push_frame(16'h0000, 4);
    enable = 1'b1;
    wait_pulse("wait_lz_0000");
    enable = 1'b0;
    repeat (3) tick();

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
